// File: rtl/l1_line_responder_if.sv
// Bundles the L1 line request/response and the physical-memory burst signals.
// The master modport is the environment (L1 controller plus memory); slave is the responder.
interface l1_line_responder_if #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
);
    logic [31:0]          line_addr;
    logic                 line_read;
    logic                 line_write;
    logic [LINE_BITS-1:0] line_wdata;
    logic [LINE_BITS-1:0] line_rdata;
    logic                 line_resp;

    logic [31:0]          burst_addr;
    logic                 burst_read;
    logic                 burst_write;
    logic [BEAT_BITS-1:0] burst_wdata;
    logic [BEAT_BITS-1:0] burst_rdata;
    logic                 burst_resp;

    modport master (
        output line_addr, line_read, line_write, line_wdata, burst_rdata, burst_resp,
        input  line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata
    );

    modport slave (
        input  line_addr, line_read, line_write, line_wdata, burst_rdata, burst_resp,
        output line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/l1_line_responder.sv
// Converts one whole-line L1 fill or writeback into a fixed-length beat burst
// on the physical-memory port, then pulses line_resp for one cycle.
module l1_line_responder #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
) (
    input logic              clk,
    input logic              rst,
    l1_line_responder_if.slave bus
);
    localparam int unsigned BEATS    = LINE_BITS / BEAT_BITS;
    localparam int unsigned KW       = $clog2(BEATS);
    localparam int unsigned OFF_BITS = $clog2(LINE_BITS / 8);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
    localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [KW-1:0]                        beat;
    logic [31:0]                          addr_q;
    logic [BEATS-1:0][BEAT_BITS-1:0]      wline_q;
    logic [BEATS-1:0][BEAT_BITS-1:0]      rline_q;
    logic                                 last_beat;

    assign last_beat = bus.burst_resp && (beat == LAST_BEAT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; write wins over read so a dirty victim leaves before its fill
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.line_write) begin
                    state_nxt = WR_BURST;
                end else if (bus.line_read) begin
                    state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                if (last_beat) begin
                    state_nxt = RESP;
                end
            end
            WR_BURST: begin
                if (last_beat) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        bus.burst_read  = 1'b0;
        bus.burst_write = 1'b0;
        bus.line_resp   = 1'b0;
        bus.burst_wdata = '0;
        case (state)
            RD_BURST: bus.burst_read = 1'b1;
            WR_BURST: begin
                bus.burst_write = 1'b1;
                bus.burst_wdata = wline_q[beat];
            end
            RESP:     bus.line_resp = 1'b1;
            default: begin
            end
        endcase
    end

    // Datapath: address/line capture at acceptance, beat counter, fill assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat    <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.line_write) begin
                        addr_q  <= bus.line_addr & ADDR_MASK;
                        wline_q <= bus.line_wdata;
                    end else if (bus.line_read) begin
                        addr_q <= bus.line_addr & ADDR_MASK;
                    end
                end
                RD_BURST: begin
                    if (bus.burst_resp) begin
                        rline_q[beat] <= bus.burst_rdata;
                        beat          <= beat + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (bus.burst_resp) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.burst_addr = addr_q;
    assign bus.line_rdata = rline_q;
endmodule

// File: tb/tb_l1_line_responder.sv
// Directed bench for l1_line_responder: fill, gapped writeback, write/read collision,
// mid-burst reset, and spurious beat responses.
module tb_l1_line_responder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    l1_line_responder_if #(.LINE_BITS(256), .BEAT_BITS(64)) bus ();

    l1_line_responder #(.LINE_BITS(256), .BEAT_BITS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [63:0]  rb1 [4];
    logic [63:0]  rb2 [4];
    logic [63:0]  rb3 [4];
    logic [63:0]  wb  [4];
    logic [255:0] rl1;
    logic [255:0] rl2;
    logic [255:0] rl3;
    logic [255:0] wl;

    initial begin
        total = 0;
        bad   = 0;
        rb1 = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        rb2 = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
        rb3 = '{64'hC0C0_0000_0000_0000, 64'hC1C1_0000_0000_0001,
                64'hC2C2_0000_0000_0002, 64'hC3C3_0000_0000_0003};
        wb  = '{64'hDEAD_0000_0000_BEEF, 64'hDEAD_1111_1111_BEEF,
                64'hDEAD_2222_2222_BEEF, 64'hDEAD_3333_3333_BEEF};
        rl1 = {rb1[3], rb1[2], rb1[1], rb1[0]};
        rl2 = {rb2[3], rb2[2], rb2[1], rb2[0]};
        rl3 = {rb3[3], rb3[2], rb3[1], rb3[0]};
        wl  = {wb[3], wb[2], wb[1], wb[0]};

        rst              = 1'b1;
        bus.line_addr    = '0;
        bus.line_read    = 1'b0;
        bus.line_write   = 1'b0;
        bus.line_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
        repeat (2) tick();

        check("rst_line_resp",   256'(bus.line_resp),   256'd0);
        check("rst_burst_read",  256'(bus.burst_read),  256'd0);
        check("rst_burst_write", 256'(bus.burst_write), 256'd0);
        check("rst_burst_addr",  256'(bus.burst_addr),  256'd0);
        check("rst_burst_wdata", 256'(bus.burst_wdata), 256'd0);
        check("rst_line_rdata",  bus.line_rdata,        256'd0);
        rst = 1'b0;
        tick();

        // Fill with consecutive beats; line_addr changes mid-burst
        bus.line_addr = 32'h0000_1234;
        bus.line_read = 1'b1;
        tick();
        check("rd1_strobe", 256'(bus.burst_read), 256'd1);
        check("rd1_addr",   256'(bus.burst_addr), 256'h0000_1220);
        check("rd1_noresp", 256'(bus.line_resp),  256'd0);
        for (int i = 0; i < 4; i++) begin
            bus.burst_rdata = rb1[i];
            bus.burst_resp  = 1'b1;
            if (i == 1) bus.line_addr = 32'hFFFF_FFFF;
            tick();
            if (i < 3) begin
                check($sformatf("rd1_strobe_b%0d", i), 256'(bus.burst_read), 256'd1);
                check($sformatf("rd1_addr_b%0d", i),   256'(bus.burst_addr), 256'h0000_1220);
                check($sformatf("rd1_noresp_b%0d", i), 256'(bus.line_resp),  256'd0);
            end
        end
        check("rd1_resp",      256'(bus.line_resp),  256'd1);
        check("rd1_strobe_lo", 256'(bus.burst_read), 256'd0);
        check("rd1_line",      bus.line_rdata,       rl1);
        bus.line_read   = 1'b0;
        bus.line_addr   = 32'h0000_0000;
        bus.burst_rdata = '1;
        tick();
        check("rd1_resp_once",   256'(bus.line_resp),  256'd0);
        check("spur_resp_line",  bus.line_rdata,       rl1);
        check("spur_resp_read",  256'(bus.burst_read), 256'd0);
        tick();
        check("spur_idle_read",  256'(bus.burst_read),  256'd0);
        check("spur_idle_write", 256'(bus.burst_write), 256'd0);
        check("spur_idle_resp",  256'(bus.line_resp),   256'd0);
        check("spur_idle_line",  bus.line_rdata,        rl1);
        bus.burst_resp = 1'b0;

        // Writeback with one idle cycle between beats
        bus.line_addr  = 32'h0000_ABCD;
        bus.line_wdata = wl;
        bus.line_write = 1'b1;
        tick();
        check("wr_strobe",  256'(bus.burst_write), 256'd1);
        check("wr_noread",  256'(bus.burst_read),  256'd0);
        check("wr_addr",    256'(bus.burst_addr),  256'h0000_ABC0);
        check("wr_wdata0",  256'(bus.burst_wdata), 256'(wb[0]));
        bus.line_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp = 1'b0;
            tick();
            check($sformatf("wr_hold_b%0d", i),   256'(bus.burst_wdata), 256'(wb[i]));
            check($sformatf("wr_strobe_b%0d", i), 256'(bus.burst_write), 256'd1);
            check($sformatf("wr_noresp_b%0d", i), 256'(bus.line_resp),   256'd0);
            bus.burst_resp = 1'b1;
            tick();
            if (i < 3) check($sformatf("wr_next_b%0d", i), 256'(bus.burst_wdata), 256'(wb[i+1]));
        end
        check("wr_resp",       256'(bus.line_resp),   256'd1);
        check("wr_strobe_lo",  256'(bus.burst_write), 256'd0);
        check("wr_wdata_lo",   256'(bus.burst_wdata), 256'd0);
        check("wr_line_kept",  bus.line_rdata,        rl1);
        bus.burst_resp = 1'b0;
        bus.line_write = 1'b0;
        tick();
        check("wr_resp_once",  256'(bus.line_resp),   256'd0);

        // Read and write together: write first, then the held read
        bus.line_addr  = 32'h0000_2000;
        bus.line_wdata = wl;
        bus.line_read  = 1'b1;
        bus.line_write = 1'b1;
        tick();
        check("both_wr_first", 256'(bus.burst_write), 256'd1);
        check("both_no_rd",    256'(bus.burst_read),  256'd0);
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp = 1'b1;
            tick();
            check($sformatf("both_excl_w%0d", i), 256'(bus.burst_read & bus.burst_write), 256'd0);
        end
        check("both_wr_resp", 256'(bus.line_resp), 256'd1);
        bus.line_write = 1'b0;
        bus.burst_resp = 1'b0;
        tick();
        check("both_idle_resp", 256'(bus.line_resp),  256'd0);
        check("both_idle_rd",   256'(bus.burst_read), 256'd0);
        tick();
        check("both_rd_strobe", 256'(bus.burst_read),  256'd1);
        check("both_rd_nowr",   256'(bus.burst_write), 256'd0);
        check("both_rd_addr",   256'(bus.burst_addr),  256'h0000_2000);
        for (int i = 0; i < 4; i++) begin
            bus.burst_rdata = rb2[i];
            bus.burst_resp  = 1'b1;
            tick();
            check($sformatf("both_excl_r%0d", i), 256'(bus.burst_read & bus.burst_write), 256'd0);
        end
        check("both_rd_resp", 256'(bus.line_resp), 256'd1);
        check("both_rd_line", bus.line_rdata,      rl2);
        bus.line_read  = 1'b0;
        bus.burst_resp = 1'b0;
        tick();

        // Reset during beat 2 of a read
        bus.line_addr = 32'h0000_3000;
        bus.line_read = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.burst_rdata = rb2[i];
            bus.burst_resp  = 1'b1;
            tick();
        end
        bus.burst_rdata = rb2[2];
        #2 rst = 1'b1;
        #1;
        check("arst_read",  256'(bus.burst_read),  256'd0);
        check("arst_resp",  256'(bus.line_resp),   256'd0);
        check("arst_addr",  256'(bus.burst_addr),  256'd0);
        check("arst_line",  bus.line_rdata,        256'd0);
        check("arst_wdata", 256'(bus.burst_wdata), 256'd0);
        tick();
        rst            = 1'b0;
        bus.burst_resp = 1'b0;
        check("arst_hold_resp", 256'(bus.line_resp), 256'd0);
        tick();
        check("post_rst_strobe", 256'(bus.burst_read), 256'd1);
        check("post_rst_addr",   256'(bus.burst_addr), 256'h0000_3000);
        for (int i = 0; i < 4; i++) begin
            bus.burst_rdata = rb3[i];
            bus.burst_resp  = 1'b1;
            tick();
            if (i < 3) check($sformatf("post_rst_noresp_b%0d", i), 256'(bus.line_resp), 256'd0);
        end
        check("post_rst_resp", 256'(bus.line_resp), 256'd1);
        check("post_rst_line", bus.line_rdata,      rl3);
        bus.line_read  = 1'b0;
        bus.burst_resp = 1'b0;
        tick();
        check("post_rst_resp_once", 256'(bus.line_resp), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
